width_packer: RTL and testbench

Packs a narrow valid/ready word stream into wide words of PACK_FACTOR lanes for the wide datapath that consumes it. It sits directly downstream of the round-robin arbiter and takes its `dout`/`valid` output, driving the arbiter's `ready`. A partially filled word is emitted on an explicit flush or after a configurable idle timeout, with a lane count so the consumer can discard the unused lanes.

---
 rtl/width_packer_pkg.sv | 12 +
 rtl/pack_timeout_counter.sv | 36 +++
 rtl/width_packer.sv | 107 ++++++++++
 tb/tb_width_packer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/width_packer_pkg.sv
// Shared helpers for the width packer and its idle-flush timer.
// Latency: none (constants and constant functions only).
// Backpressure: not applicable.
package width_packer_pkg;

  // Bits needed by an idle timer that saturates at limit-1 (minimum 1 bit).
  function automatic int timer_width(input int limit);
    if (limit <= 2) return 1;
    return $clog2(limit);
  endfunction

endpackage

// File: rtl/pack_timeout_counter.sv
// Idle timer: raises expired on the LIMIT-th consecutive enabled cycle.
// Latency: expired is combinational from the timer state and enable.
// Backpressure: none; clear has priority over counting, LIMIT=0 never expires.
module pack_timeout_counter
  import width_packer_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = timer_width(LIMIT);
  localparam logic [TW-1:0] LAST = (LIMIT == 0) ? '0 : TW'(LIMIT - 1);

  logic [TW-1:0] timer;

  // The register holds the number of idle cycles already completed, so the
  // current idle cycle is the LIMIT-th one when the register reads LIMIT-1.
  assign expired = (LIMIT != 0) && enable && (timer == LAST);

  // Count enabled cycles, saturating so a held-off flush keeps expired high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (enable && (timer != LAST)) begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/width_packer.sv
// Packs narrow valid/ready words into PACK_FACTOR-lane wide words with a lane count.
// Latency: completing or flushing accept at cycle t gives out_valid at t+1.
// Backpressure: in_ready drops while a full word or pending flush waits for the output slot.
module width_packer #(
  parameter int PACK_FACTOR   = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                flush,
  output logic [PACK_FACTOR*DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(PACK_FACTOR+1)-1:0]    out_count,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int COUNT_W = $clog2(PACK_FACTOR + 1);
  localparam int OUT_W   = PACK_FACTOR * DATA_WIDTH;
  localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(PACK_FACTOR);

  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] count_nxt;
  logic [OUT_W-1:0]   acc;
  logic [OUT_W-1:0]   acc_nxt;
  logic               pend;
  logic               accept;
  logic               slot_free;
  logic               has_data;
  logic               flush_evt;
  logic               load;
  logic               expired;
  logic               timer_clear;
  logic               timer_enable;

  assign in_ready  = rst_n && (count < FULL_CNT) && !pend;
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;
  assign count_nxt = count + COUNT_W'(accept);
  assign has_data  = (count_nxt != '0);
  assign flush_evt = flush || expired;
  // A word leaves the accumulator when it is full or a flush is due, and the
  // output register is empty or being drained this cycle.
  assign load      = slot_free && has_data && ((count_nxt == FULL_CNT) || pend || flush_evt);

  // Accumulator image including this cycle's accepted word in lane count.
  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < PACK_FACTOR; i++) begin
      if (accept && (count == COUNT_W'(i))) begin
        acc_nxt[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end
    end
  end

  assign timer_enable = (count != '0) && !accept;
  assign timer_clear  = accept || load || (count == '0);

  pack_timeout_counter #(
    .LIMIT (FLUSH_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (expired)
  );

  // Accumulator and pending flush: empty on load, otherwise keep filling; a
  // flush that finds the slot busy is remembered until the slot frees.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      acc   <= '0;
      pend  <= 1'b0;
    end else if (load) begin
      count <= '0;
      acc   <= '0;
      pend  <= 1'b0;
    end else begin
      count <= count_nxt;
      acc   <= acc_nxt;
      if (flush_evt && has_data) begin
        pend <= 1'b1;
      end
    end
  end

  // Output register: loads a packed word, otherwise holds until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= acc_nxt;
      out_count <= count_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_width_packer.sv
// Directed bench for width_packer: vector table plus multi-cycle corner sequences.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_width_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  width_packer #(
    .PACK_FACTOR   (4),
    .DATA_WIDTH    (8),
    .FLUSH_TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        fl;
    logic        rdy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [2:0]  e_oc;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic f, input logic r,
                              input logic ir, input logic ov, input logic [31:0] od,
                              input logic [2:0] oc);
    vec_t x;
    x.vld = v; x.dat = d; x.fl = f; x.rdy = r;
    x.e_ir = ir; x.e_ov = ov; x.e_od = od; x.e_oc = oc;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic drv(input logic v, input logic [7:0] d, input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    drv(1'b0, 8'h00, 1'b0, 1'b1);

    // Vector table: inputs for one cycle and the outputs seen in that cycle.
    vecs[0]  = mk(1, 8'h11, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[1]  = mk(1, 8'h22, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[2]  = mk(1, 8'h33, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[3]  = mk(1, 8'h44, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[4]  = mk(1, 8'hA1, 0, 1, 1, 1, 32'h44332211, 3'd4);
    vecs[5]  = mk(1, 8'hA2, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[6]  = mk(0, 8'h00, 1, 1, 1, 0, 32'h0, 3'd0);
    vecs[7]  = mk(0, 8'h00, 0, 1, 1, 1, 32'h0000A2A1, 3'd2);
    vecs[8]  = mk(0, 8'h00, 1, 1, 1, 0, 32'h0, 3'd0);
    vecs[9]  = mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[10] = mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[11] = mk(1, 8'h01, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[12] = mk(1, 8'h02, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[13] = mk(1, 8'h03, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[14] = mk(1, 8'h04, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[15] = mk(1, 8'h05, 0, 1, 1, 1, 32'h04030201, 3'd4);
    vecs[16] = mk(1, 8'h06, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[17] = mk(1, 8'h07, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[18] = mk(1, 8'h08, 0, 1, 1, 0, 32'h0, 3'd0);
    vecs[19] = mk(0, 8'h00, 0, 1, 1, 1, 32'h08070605, 3'd4);
    vecs[20] = mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 3'd0);

    // Reset behaviour.
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_rst_out_data", out_data, 32'd0);
    chk("post_rst_out_count", {29'b0, out_count}, 32'd0);
    step();

    // Table: full word, explicit flush, idle flush, back-to-back words.
    for (int i = 0; i < 21; i++) begin
      drv(vecs[i].vld, vecs[i].dat, vecs[i].fl, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
        chk($sformatf("vec%0d_out_count", i), {29'b0, out_count}, {29'b0, vecs[i].e_oc});
      end
      step();
    end

    // Idle timeout: single word, out_valid 17 cycles after its accept.
    drv(1'b1, 8'h05, 1'b0, 1'b1);
    @(negedge clk);
    chk("tmo_accept_ready", {31'b0, in_ready}, 32'd1);
    step();
    drv(1'b0, 8'h00, 1'b0, 1'b1);
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (out_valid) break;
      step();
      n++;
    end
    chk("tmo_cycles", n, 32'd17);
    chk("tmo_out_data", out_data, 32'h00000005);
    chk("tmo_out_count", {29'b0, out_count}, 32'd1);
    step();

    // Backpressure: 8 words with out_ready low, then drain.
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", i), {31'b0, in_ready}, 32'd1);
      if (i >= 4) begin
        chk($sformatf("bp_hold_valid%0d", i), {31'b0, out_valid}, 32'd1);
        chk($sformatf("bp_hold_data%0d", i), out_data, 32'h13121110);
      end
      step();
    end
    drv(1'b1, 8'h99, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_in_ready_drop", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_data_full", out_data, 32'h13121110);
    step();
    drv(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp_drain1_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_drain1_data", out_data, 32'h13121110);
    step();
    @(negedge clk);
    chk("bp_drain2_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_drain2_data", out_data, 32'h17161514);
    chk("bp_drain2_count", {29'b0, out_count}, 32'd4);
    chk("bp_drain2_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    @(negedge clk);
    chk("bp_drained", {31'b0, out_valid}, 32'd0);
    step();

    // Flush while the output slot is busy with count=3.
    for (int i = 0; i < 7; i++) begin
      drv(1'b1, (i < 4) ? (8'h20 + 8'(i)) : (8'h30 + 8'(i - 4)), 1'b0, 1'b0);
      step();
    end
    drv(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("pf_busy_valid", {31'b0, out_valid}, 32'd1);
    step();
    drv(1'b1, 8'h99, 1'b0, 1'b0);
    @(negedge clk);
    chk("pf_pending_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    drv(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("pf_held_data", out_data, 32'h23222120);
    step();
    @(negedge clk);
    chk("pf_partial_valid", {31'b0, out_valid}, 32'd1);
    chk("pf_partial_data", out_data, 32'h00323130);
    chk("pf_partial_count", {29'b0, out_count}, 32'd3);
    step();
    @(negedge clk);
    chk("pf_done_valid", {31'b0, out_valid}, 32'd0);
    chk("pf_done_in_ready", {31'b0, in_ready}, 32'd1);
    step();

    // Reset with count=2 and a held output word.
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, (i < 4) ? (8'h40 + 8'(i)) : (8'h50 + 8'(i - 4)), 1'b0, 1'b0);
      step();
    end
    rst_n = 1'b0;
    drv(1'b1, 8'h77, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("mid_rst_prev_valid", {31'b0, out_valid}, 32'd1);
    step();
    rst_n = 1'b1;
    drv(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("after_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("after_rst_data", out_data, 32'd0);
    chk("after_rst_count", {29'b0, out_count}, 32'd0);
    chk("after_rst_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 8'h60 + 8'(i), 1'b0, 1'b1);
      step();
    end
    drv(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("clean_word_valid", {31'b0, out_valid}, 32'd1);
    chk("clean_word_data", out_data, 32'h63626160);
    chk("clean_word_count", {29'b0, out_count}, 32'd4);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
